// File: rtl/arb_rr_16_pkg.sv
// Shared definitions for the 16-way round-robin arbiter.
//   NREQ        : number of requesters
//   SELW        : width of the mux select / grant index
//   arb_state_t : arbiter state (IDLE = no grant, GRANT = one requester owns mux)
//   onehot()    : decode an index into a one-hot grant vector
package arb_rr_16_pkg;

  localparam int unsigned NREQ = 16;
  localparam int unsigned SELW = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  function automatic logic [NREQ-1:0] onehot(input logic [SELW-1:0] idx);
    logic [NREQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/arb_rr_16_pick.sv
// Combinational round-robin picker.
// Finds the first set bit of req at or after ptr, searching upward and
// wrapping from 15 to 0.
//   req   : request vector
//   ptr   : search start position (highest priority)
//   idx   : index of the selected requester (0 when none found)
//   found : at least one request is set
module rr_pick_16
  import arb_rr_16_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [SELW-1:0] ptr,
  output logic [SELW-1:0] idx,
  output logic            found
);

  logic [SELW-1:0] cand;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      // Index arithmetic is modulo 16, so the addition wraps naturally.
      cand = ptr + SELW'(i);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/arb_rr_16.sv
// 16-requester round-robin arbiter driving a 16:1 mux select.
//   clk        : clock, all state updates on rising edge
//   rst_n      : synchronous active-low reset
//   req        : per-requester request
//   lock       : per-requester burst lock (only the granted bit matters)
//   res_ready  : consumer accepts the current beat
//   sel3..sel0 : registered grant index to the mux (sel3 = MSB)
//   res_valid  : mux output carries a granted beat
//   gnt        : registered one-hot grant, zero when idle
// A locked requester may keep the grant for up to LOCK_MAX consecutive beats.
module arb_rr_16
  import arb_rr_16_pkg::*;
#(
  parameter int unsigned LOCK_MAX = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] lock,
  input  logic            res_ready,
  output logic            sel3,
  output logic            sel2,
  output logic            sel1,
  output logic            sel0,
  output logic            res_valid,
  output logic [NREQ-1:0] gnt
);

  localparam int unsigned     CNTW     = $clog2(LOCK_MAX) + 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(LOCK_MAX - 1);

  arb_state_t      state_q, state_d;
  logic [SELW-1:0] ptr_q, ptr_d;
  logic [SELW-1:0] sel_q, sel_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            valid_q, valid_d;

  logic [SELW-1:0] pick_ptr;
  logic [SELW-1:0] pick_idx;
  logic            pick_found;
  logic            xfer;
  logic            hold;

  // One picker serves both cases: in IDLE it searches from ptr; in GRANT it
  // searches from g+1, which is exactly the pointer a release would store,
  // so the current owner is naturally the last candidate.
  always_comb begin
    pick_ptr = ptr_q;
    if (state_q == GRANT) begin
      pick_ptr = sel_q + SELW'(1);
    end
  end

  rr_pick_16 u_pick (
    .req   (req),
    .ptr   (pick_ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign xfer = valid_q && res_ready;
  assign hold = lock[sel_q] && req[sel_q] && (cnt_q < CNT_LAST);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = GRANT;
          sel_d   = pick_idx;
          gnt_d   = onehot(pick_idx);
          valid_d = 1'b1;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (xfer) begin
          if (hold) begin
            cnt_d = cnt_q + CNTW'(1);
          end else begin
            ptr_d = sel_q + SELW'(1);
            cnt_d = '0;
            if (pick_found) begin
              sel_d = pick_idx;
              gnt_d = onehot(pick_idx);
            end else begin
              // sel keeps the last granted index while idle.
              state_d = IDLE;
              gnt_d   = '0;
              valid_d = 1'b0;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
    end
  end

  assign sel3      = sel_q[3];
  assign sel2      = sel_q[2];
  assign sel1      = sel_q[1];
  assign sel0      = sel_q[0];
  assign gnt       = gnt_q;
  assign res_valid = valid_q;

endmodule

// File: tb/tb_arb_rr_16.sv
// Self-checking bench for arb_rr_16 (LOCK_MAX = 4): directed scenarios with
// literal expectations plus a randomized phase, all checked every cycle
// against a transaction-level model of the arbiter.
module tb_arb_rr_16;

  localparam int LMAX = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] req = '0;
  logic [15:0] lock = '0;
  logic        res_ready = 1'b0;
  logic        sel3, sel2, sel1, sel0;
  logic        res_valid;
  logic [15:0] gnt;
  logic [3:0]  sel;

  assign sel = {sel3, sel2, sel1, sel0};

  int total = 0;
  int bad   = 0;
  bit started = 1'b0;

  arb_rr_16 #(.LOCK_MAX(LMAX)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .lock      (lock),
    .res_ready (res_ready),
    .sel3      (sel3),
    .sel2      (sel2),
    .sel1      (sel1),
    .sel0      (sel0),
    .res_valid (res_valid),
    .gnt       (gnt)
  );

  always #5 clk = ~clk;

  // ---------------- model ----------------
  // m_beats = number of beats the current owner has been granted in this run.
  bit m_valid = 1'b0;
  int m_sel   = 0;
  int m_ptr   = 0;
  int m_beats = 0;

  function automatic int first_from(input logic [15:0] r, input int p);
    for (int i = 0; i < 16; i++) begin
      if (r[(p + i) % 16]) return (p + i) % 16;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    int w;
    if (!rst_n) begin
      m_valid = 1'b0; m_sel = 0; m_ptr = 0; m_beats = 0;
    end else if (!m_valid) begin
      w = first_from(req, m_ptr);
      if (w >= 0) begin
        m_valid = 1'b1; m_sel = w; m_beats = 1;
      end
    end else if (res_ready) begin
      if (lock[m_sel] && req[m_sel] && m_beats < LMAX) begin
        m_beats++;
      end else begin
        m_ptr = (m_sel + 1) % 16;
        w = first_from(req, m_ptr);
        if (w >= 0) begin
          m_sel = w; m_beats = 1;
        end else begin
          m_valid = 1'b0; m_beats = 0;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", nm, got, exp, $time);
    end
  endtask

  // Every-cycle comparison of DUT against the model.
  always @(negedge clk) begin
    if (started) begin
      chk("cyc_valid", 32'(res_valid), 32'(m_valid));
      chk("cyc_sel", 32'(sel), 32'(m_sel));
      chk("cyc_gnt", 32'(gnt), m_valid ? (32'd1 << m_sel) : 32'd0);
    end
  end

  // Literal expectations: pin both the DUT and the model.
  task automatic chk_grant(input string nm, input int exp);
    chk({nm, "_valid"}, 32'(res_valid), 32'd1);
    chk({nm, "_sel"}, 32'(sel), 32'(exp));
    chk({nm, "_gnt"}, 32'(gnt), 32'd1 << exp);
    chk({nm, "_model"}, 32'(m_sel), 32'(exp));
  endtask

  task automatic chk_idle(input string nm, input int exp_sel);
    chk({nm, "_valid"}, 32'(res_valid), 32'd0);
    chk({nm, "_gnt"}, 32'(gnt), 32'd0);
    chk({nm, "_sel"}, 32'(sel), 32'(exp_sel));
    chk({nm, "_model"}, 32'(m_valid), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0; lock = '0; res_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset then idle with no requests.
    @(negedge clk);
    do_reset();
    started = 1'b1;
    chk_idle("reset", 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_idle("idle5", 0);
    end

    // Two requesters alternate with no bubbles.
    do_reset();
    req = 16'h8001; res_ready = 1'b1;
    @(negedge clk); chk_grant("alt0", 0);
    @(negedge clk); chk_grant("alt1", 15);
    @(negedge clk); chk_grant("alt2", 0);
    @(negedge clk); chk_grant("alt3", 15);

    // Grant held while consumer stalls; sel kept after going idle.
    do_reset();
    req = 16'h0010; res_ready = 1'b0;
    @(negedge clk); chk_grant("stall0", 4);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk_grant("stall_hold", 4);
    end
    res_ready = 1'b1; req = '0;
    @(negedge clk); chk_idle("stall_done", 4);

    // Locked burst of LOCK_MAX beats.
    do_reset();
    req = 16'h0006; lock = 16'h0002; res_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); chk_grant("lock_burst", 1);
    end
    @(negedge clk); chk_grant("lock_next", 2);
    @(negedge clk); chk_grant("lock_back", 1);

    // Pointer wrap from 15 to 0.
    do_reset();
    req = 16'h4000; res_ready = 1'b1;
    @(negedge clk); chk_grant("wrap14", 14);
    req = 16'h4001;
    @(negedge clk); chk_grant("wrap0", 0);
    @(negedge clk); chk_grant("wrap14b", 14);

    // Reset mid-burst.
    do_reset();
    req = 16'h0006; lock = 16'h0002; res_ready = 1'b1;
    @(negedge clk); chk_grant("rb_beat1", 1);
    @(negedge clk); chk_grant("rb_beat2", 1);
    rst_n = 1'b0;
    @(negedge clk); chk_idle("rb_reset", 0);
    rst_n = 1'b1;
    @(negedge clk); chk_grant("rb_regrant", 1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      rst_n     = ($urandom_range(0, 249) != 0);
      req       = ($urandom_range(0, 4) == 0) ? 16'h0000 : 16'($urandom & $urandom);
      lock      = 16'($urandom | $urandom);
      res_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
